// File: rtl/seq_pattern_tx_if.sv
// Frame-request / serial-output bundle for seq_pattern_tx.
// The master side requests frames and the slave side (the transmitter) drives the serial stream.
interface seq_pattern_tx_if #(
    parameter int WIDTH = 8
);
    localparam int LW = $clog2(WIDTH) + 1;

    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [LW-1:0]    len;
    logic             o_p;
    logic             ready;
    logic             busy;
    logic             done;

    modport master (
        output start, data_in, len,
        input  o_p, ready, busy, done
    );

    modport slave (
        input  start, data_in, len,
        output o_p, ready, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts out a captured frame of 1..WIDTH bits on o_p.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit after the data bits.
//
//   state  | meaning
//   IDLE   | ready for a start, o_p held low
//   SEND   | o_p carries a data bit, cnt_q counts the bits still to follow
//   PARITY | o_p carries the even-parity bit (parity build only)
module seq_pattern_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    seq_pattern_tx_if.slave bus
);
    localparam int            LW       = $clog2(WIDTH) + 1;
    localparam logic [LW-1:0] FULL_LEN = LW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SEND, PARITY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] aligned;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    frame_len;
    logic             o_p_q, o_p_d;
    logic             done_q, done_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    // MSB-first frames shorter than WIDTH are left-justified so bit N-1 leads.
    always_comb begin
        frame_len = bus.len;
        if (bus.len == '0 || bus.len > FULL_LEN)
            frame_len = FULL_LEN;
        aligned = MSB_FIRST ? (bus.data_in << (FULL_LEN - frame_len)) : bus.data_in;
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        o_p_d    = 1'b0;
        done_d   = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = SEND;
                    o_p_d    = head(aligned);
                    shift_d  = advance(aligned);
                    cnt_d    = frame_len - 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    parity_d = head(aligned);
`endif
                end
            end
            SEND: begin
                if (cnt_q == '0) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    state_d = PARITY;
                    o_p_d   = parity_q;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    o_p_d    = head(shift_q);
                    shift_d  = advance(shift_q);
                    cnt_d    = cnt_q - 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    parity_d = parity_q ^ head(shift_q);
`endif
                end
            end
            PARITY: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            o_p_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            o_p_q    <= o_p_d;
            done_q   <= done_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.o_p   = o_p_q;
    assign bus.ready = (state_q == IDLE);
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one MSB-first and one LSB-first instance.
// Observation word per cycle is {o_p, busy, ready, done}.
module tb_seq_pattern_tx;
    localparam int W  = 8;
    localparam int LW = $clog2(W) + 1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    seq_pattern_tx_if #(.WIDTH(W)) bm ();
    seq_pattern_tx_if #(.WIDTH(W)) bl ();

    seq_pattern_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clock(clock), .reset(reset), .bus(bm));
    seq_pattern_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clock(clock), .reset(reset), .bus(bl));

    typedef struct {
        bit            sel_msb;
        logic [W-1:0]  data;
        logic [LW-1:0] len;
        int            nbits;
        logic [15:0]   seq;   // seq[k] is the k-th transmitted bit
        logic          par;
    } vec_t;

    vec_t vecs [7];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic s, input logic [W-1:0] d, input logic [LW-1:0] l);
        if (sel) begin
            bm.start = s; bm.data_in = d; bm.len = l;
        end else begin
            bl.start = s; bl.data_in = d; bl.len = l;
        end
    endtask

    function automatic logic [3:0] obs(input bit sel);
        return sel ? {bm.o_p, bm.busy, bm.ready, bm.done}
                   : {bl.o_p, bl.busy, bl.ready, bl.done};
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int   total;
        logic exp_op;
        total = v.nbits + PAR;
        @(posedge clock); #1;
        drive(v.sel_msb, 1'b1, v.data, v.len);
        @(posedge clock); #1;
        drive(v.sel_msb, 1'b0, ~v.data, LW'(1));
        for (int k = 0; k < total; k++) begin
            @(negedge clock);
            exp_op = (k < v.nbits) ? v.seq[k] : v.par;
            check($sformatf("vec%0d bit%0d", idx, k), obs(v.sel_msb), {exp_op, 1'b1, 1'b0, 1'b0});
        end
        @(negedge clock);
        check($sformatf("vec%0d done", idx), obs(v.sel_msb), 4'b0011);
        @(negedge clock);
        check($sformatf("vec%0d post", idx), obs(v.sel_msb), 4'b0010);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 8'h0B, 4'd4, 4, 16'h000D, 1'b1};
        vecs[1] = '{1'b0, 8'h06, 4'd3, 3, 16'h0006, 1'b0};
        vecs[2] = '{1'b1, 8'hC5, 4'd0, 8, 16'h00A3, 1'b0};
        vecs[3] = '{1'b1, 8'hA7, 4'd8, 8, 16'h00E5, 1'b1};
        vecs[4] = '{1'b0, 8'h3C, 4'd9, 8, 16'h003C, 1'b0};
        vecs[5] = '{1'b1, 8'h01, 4'd1, 1, 16'h0001, 1'b1};
        vecs[6] = '{1'b0, 8'h81, 4'd8, 8, 16'h0081, 1'b0};

        // reset held while start is asserted: reset wins
        drive(1'b1, 1'b1, 8'hFF, 4'd8);
        drive(1'b0, 1'b1, 8'hFF, 4'd8);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset msb", obs(1'b1), 4'b0010);
        check("reset lsb", obs(1'b0), 4'b0010);
        @(posedge clock); #1;
        reset = 1'b0;
        drive(1'b1, 1'b0, '0, '0);
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clock);
        check("idle msb", obs(1'b1), 4'b0010);
        check("idle lsb", obs(1'b0), 4'b0010);

        for (int i = 0; i < 7; i++)
            run_vec(i, vecs[i]);

        // start held high through a C5 frame, data changed after acceptance
        @(posedge clock); #1;
        drive(1'b1, 1'b1, 8'hC5, 4'd0);
        @(posedge clock); #1;
        drive(1'b1, 1'b1, 8'h00, 4'd3);
        for (int k = 0; k < 8 + PAR; k++) begin
            @(negedge clock);
            check($sformatf("held bit%0d", k), obs(1'b1),
                  {(k < 8) ? vecs[2].seq[k] : 1'b0, 1'b1, 1'b0, 1'b0});
        end
        @(negedge clock);
        check("held done", obs(1'b1), 4'b0011);
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 8'hFF, 4'd8);
        for (int k = 0; k < 3 + PAR; k++) begin
            @(negedge clock);
            check($sformatf("restart bit%0d", k), obs(1'b1), 4'b0100);
        end
        @(negedge clock);
        check("restart done", obs(1'b1), 4'b0011);

        // back-to-back: start in the done cycle
        @(posedge clock); #1;
        drive(1'b1, 1'b1, 8'h0B, 4'd4);
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 8'h00, 4'd0);
        for (int k = 0; k < 4 + PAR; k++) begin
            @(negedge clock);
            check($sformatf("b2b first bit%0d", k), obs(1'b1),
                  {(k < 4) ? vecs[0].seq[k] : 1'b1, 1'b1, 1'b0, 1'b0});
        end
        @(posedge clock); #1;
        drive(1'b1, 1'b1, 8'h06, 4'd4);
        @(negedge clock);
        check("b2b gap", obs(1'b1), 4'b0011);
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 8'hFF, 4'd1);
        begin
            logic [3:0] seq2;
            seq2 = 4'b0110;
            for (int k = 0; k < 4 + PAR; k++) begin
                @(negedge clock);
                check($sformatf("b2b second bit%0d", k), obs(1'b1),
                      {(k < 4) ? seq2[k] : 1'b0, 1'b1, 1'b0, 1'b0});
            end
        end
        @(negedge clock);
        check("b2b done", obs(1'b1), 4'b0011);

        // reset at the third bit of an 8-bit frame
        @(posedge clock); #1;
        drive(1'b1, 1'b1, 8'hFF, 4'd8);
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 8'h00, 4'd0);
        @(negedge clock);
        check("rst bit0", obs(1'b1), 4'b1100);
        @(negedge clock);
        check("rst bit1", obs(1'b1), 4'b1100);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rst bit2", obs(1'b1), 4'b1100);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst after", obs(1'b1), 4'b0010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("rst no done %0d", k), obs(1'b1), 4'b0010);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the maximum frame length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = highest frame bit first, 0 = bit 0 first.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, frame request; sampled only while ready=1.
REQ-006 The block SHALL have port data_in, input, WIDTH bits, frame pattern; captured on an accepted start.
REQ-007 The block SHALL have port len, input, $clog2(WIDTH)+1 bits, frame length in bits; captured on an accepted start.
REQ-008 The block SHALL have port o_p, output, 1 bit, serial pattern bit (registered); this is the serial stream a Moore sequence detector samples.
REQ-009 The block SHALL have port ready, output, 1 bit, high when a start would be accepted.
REQ-010 The block SHALL have port busy, output, 1 bit, high while frame bits are being driven.
REQ-011 The block SHALL have port done, output, 1 bit, one-cycle pulse after a frame completes.

Function
REQ-012 The block SHALL implement states IDLE, SEND and PARITY; PARITY is reachable only when PARITY_EN is defined.
REQ-013 The block SHALL accept start only in IDLE: ready=1 in IDLE, 0 otherwise.
REQ-014 The block SHALL, on an edge where start=1 and ready=1, capture data_in into a shift register and len into a bit counter, then enter SEND.
REQ-015 The block SHALL use a frame length of WIDTH when len=0 or len>WIDTH.
REQ-016 The block SHALL drive the first frame bit on o_p during the cycle after acceptance (latency 1), then one new bit per clock for exactly N cycles.
REQ-017 The block SHALL send data_in[N-1] down to data_in[0] when MSB_FIRST=1, and data_in[0] up to data_in[N-1] when MSB_FIRST=0.
REQ-018 The block SHALL hold busy=1 for every cycle that o_p carries a frame bit (data or parity), and busy=0 otherwise.
REQ-019 The block SHALL drive o_p=0 whenever busy=0.
REQ-020 The block SHALL, in the cycle after the final frame bit, return to IDLE with busy=0, ready=1, done=1 for that single cycle.
REQ-021 The block SHALL ignore start while busy: no recapture, no change to the bit stream.
REQ-022 The block SHALL accept a start that arrives in the done cycle, giving back-to-back frames separated by exactly one idle cycle (o_p=0).
REQ-023 The block SHALL ignore data_in and len changes after acceptance for the current frame.

Reset
REQ-024 The block SHALL, on any edge with reset=1, enter IDLE with o_p=0, busy=0, done=0, ready=1, and clear the shift register and counter.
REQ-025 The block SHALL abandon a frame that is reset mid-operation with no done pulse, and SHALL take reset priority over a simultaneous start.

Configuration
REQ-026 The block SHALL, with macro SEQ_PATTERN_TX_PARITY_EN defined, append one even-parity bit (XOR of the N transmitted data bits) in PARITY state after the last data bit, with busy=1, and pulse done one cycle later.
REQ-027 The block SHALL, without SEQ_PATTERN_TX_PARITY_EN, send data bits only, and done SHALL follow the last data bit.

Verification
REQ-028 The bench SHALL cover MSB_FIRST=1, len=4, data_in=4'b1011, start pulsed at cycle 0 -> o_p=1,0,1,1 in cycles 1-4; done=1 and o_p=0 in cycle 5.
REQ-029 The bench SHALL cover MSB_FIRST=0, len=3, data_in=3'b110 -> o_p=0,1,1, then done.
REQ-030 The bench SHALL cover len=0, data_in=8'hC5, MSB-first -> 8 bits 1,1,0,0,0,1,0,1; start held high throughout the frame -> no restart until the done cycle.
REQ-031 The bench SHALL cover start in the done cycle with data_in=4'b0110, len=4 -> o_p=0 for one cycle, then 0,1,1,0.
REQ-032 The bench SHALL cover reset=1 at the third bit of an 8-bit frame -> next cycle o_p=0, busy=0, ready=1, no done pulse.
REQ-033 The bench SHALL cover SEQ_PATTERN_TX_PARITY_EN defined, data_in=8'hA7, len=8 -> 1,0,1,0,0,1,1,1 then parity 1, then done.
